psx_poll_master: RTL and testbench
==================================

# psx_poll_master

Console-side PlayStation controller poll master: generates the `att`/`psx_clk`/`cmd` bus that the fake controller consumes and collects its `data`/`ack` replies. Runs a fixed 5-byte digital-pad poll frame (0x01, 0x42, 0x00, 0x00, 0x00) and presents the 16-bit button word with a one-cycle valid strobe. It sits directly upstream of `fake_controller` and replaces the Saleae capture playback as the bus source.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per `psx_clk` half-period; minimum 4.
- `ATT_SETUP`, default 8: `clk` cycles from `att` falling to the first `psx_clk` falling.
- `ACK_TIMEOUT`, default 64: `clk` cycles allowed from the end of a byte to `ack` low.
- `GAP`, default 16: `clk` cycles with `att` high after every frame, good or aborted.
- `POLL_PERIOD`, default 4000: `clk` cycles between automatic poll starts (auto mode only).

- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to run a frame; ignored while `busy`.
- `data` in 1: controller-to-host serial data, LSB first, asynchronous to `clk`.
- `ack` in 1: controller acknowledge, active-low, asynchronous to `clk`.
- `att` out 1: attention / chip-select, active-low.
- `psx_clk` out 1: serial clock, idles high.
- `cmd` out 1: host-to-controller serial data, LSB first, idles high.
- `buttons_n` out 16: last good button word, active-low as on the wire; `{byte4, byte3}`.
- `pad_id` out 8: byte received during TX byte 1 of the last good frame (0x41 = digital pad).
- `valid` out 1: one-cycle pulse when `buttons_n` and `pad_id` update.
- `error` out 1: one-cycle pulse on an aborted frame.
- `busy` out 1: high from frame start through the end of GAP.

## Operation
- `data` and `ack` pass through 2-flop synchronizers before any use.
- States:
  - IDLE
  - SETUP: `att` low, wait ATT_SETUP cycles.
  - SHIFT: 8 bits.
  - ACKWAIT
  - GAP: `att` high.
- Transitions:
  - IDLE→SETUP on `start`, or on the auto-poll tick.
  - SETUP→SHIFT.
  - SHIFT→ACKWAIT after bytes 0–3.
  - SHIFT→GAP after byte 4, with validation.
  - ACKWAIT→SHIFT (next byte) when synchronized `ack` is seen low.
  - ACKWAIT→GAP with `error` on timeout.
  - GAP→IDLE.
- Per bit:
  - Drive `cmd` = TX bit and `psx_clk` low for CLK_DIV cycles.
  - Then drive `psx_clk` high for CLK_DIV cycles.
  - Sample synchronized `data` into the RX shift register on the cycle `psx_clk` goes high; shift in LSB first.
- ACKWAIT waits for `ack` low (not its return high).
- Validation after byte 4:
  - The RX byte during TX byte 2 must be 0x5A; otherwise pulse `error` and hold the outputs.
  - On success, update `buttons_n` and `pad_id` and pulse `valid` on the same cycle.
- The byte counter runs 0..4 and never wraps inside a frame.

## Timing
- Reset values:
  - `att` = 1, `psx_clk` = 1, `cmd` = 1.
  - `buttons_n` = 16'hFFFF, `pad_id` = 8'hFF.
  - `valid` = 0, `error` = 0, `busy` = 0.
  - State = IDLE; all counters = 0.
- Start latency: `att` falls and `busy` rises 1 cycle after `start` is sampled high.
- Bit cell is 2·CLK_DIV cycles; a byte is 16·CLK_DIV cycles.
- `cmd` changes only on the cycle `psx_clk` falls, and is held through the high phase.
- `psx_clk` returns high before ACKWAIT; `cmd` returns to 1 at each byte end.
- Ack acceptance: the next byte's first `psx_clk` falls 1 cycle after synchronized `ack` = 0 is seen.
- Timeout fires on cycle ACK_TIMEOUT of ACKWAIT; the counter is reset on entering ACKWAIT.
- `valid` / `error` assert in the cycle `att` rises; `busy` falls GAP cycles later.
- Boundary conditions:
  - An `ack` already low on entering ACKWAIT counts immediately.
  - `start` during `busy` is dropped, not queued.
  - `start` coinciding with an auto tick produces one frame.
  - `rst` mid-frame returns all outputs to reset values asynchronously, with no partial `valid` or `error`.

## Configuration
- `PSX_POLL_AUTO_EN` defined: a free-running counter raises an internal start tick every POLL_PERIOD cycles; `start` still works, and ticks arriving while busy are dropped.
- `PSX_POLL_AUTO_EN` undefined: frames run only on `start`; the POLL_PERIOD counter is not built.

## Structure
- Package `psx_pkg` holds:
  - Command bytes PSX_CMD_START (0x01), PSX_CMD_POLL (0x42), PSX_CMD_IDLE (0x00).
  - PSX_ID_MARK (0x5A), PSX_FRAME_BYTES (5).
  - State enum `psx_state_t`.
- Sub-module `psx_byte_xfer` handles one byte: it takes the TX byte and a go pulse, generates `psx_clk`/`cmd`, and returns the RX byte with a done pulse. The top level owns `att`, ACKWAIT, validation and GAP.

## Test plan
- Reset mid-SHIFT of byte 2 → `att` = 1, `psx_clk` = 1, `cmd` = 1 at once; `buttons_n` = FFFF; no `valid`.
- `start` with a bench controller returning FF/41/5A/FB/7F, each ack after 10 cycles → one `valid`, `pad_id` = 0x41, `buttons_n` = 16'h7FFB.
- Check the `cmd` bit stream: with CLK_DIV = 4, byte 1 on `cmd` reads 0x42 LSB first, one bit per 8 cycles, changing only on `psx_clk` falling.
- Controller withholds ack after byte 1 → `error` exactly ACK_TIMEOUT cycles into ACKWAIT, `att` high, outputs unchanged, `busy` low GAP cycles later.
- Byte 2 reply 0x00 instead of 0x5A → `error`, no `valid`, previous `buttons_n` held.
- `PSX_POLL_AUTO_EN` build, POLL_PERIOD = 4000, no `start` → frames start every 4000 cycles; a `start` pulsed mid-frame creates no extra frame.

Source files
------------

// File: rtl/psx_pkg.sv
// Shared constants, frame command bytes and FSM state type for the PSX poll master.
package psx_pkg;

    localparam logic [7:0] PSX_CMD_START = 8'h01;
    localparam logic [7:0] PSX_CMD_POLL  = 8'h42;
    localparam logic [7:0] PSX_CMD_IDLE  = 8'h00;
    localparam logic [7:0] PSX_ID_MARK   = 8'h5A;
    localparam int unsigned PSX_FRAME_BYTES = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_ACKWAIT,
        ST_GAP
    } psx_state_t;

    function automatic logic [7:0] psx_tx_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return PSX_CMD_START;
            3'd1:    return PSX_CMD_POLL;
            default: return PSX_CMD_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/psx_byte_xfer.sv
// One-byte PSX serial transfer: drives psx_clk/cmd LSB first and shifts in data.
module psx_byte_xfer #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       go_i,
    input  logic [7:0] tx_i,
    input  logic       data_i,
    output logic       sclk_o,
    output logic       cmd_o,
    output logic [7:0] rx_o,
    output logic       done_o
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic          active_q, active_d;
    logic          sclk_q, sclk_d;
    logic          cmd_q, cmd_d;
    logic [2:0]    bit_q, bit_d;
    logic [DW-1:0] div_q, div_d;
    logic [7:0]    tx_q, tx_d;
    logic [7:0]    rx_q, rx_d;
    logic          phase_end;

    always_comb begin
        active_d  = active_q;
        sclk_d    = sclk_q;
        cmd_d     = cmd_q;
        bit_d     = bit_q;
        div_d     = div_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        done_o    = 1'b0;
        phase_end = (div_q == DW'(CLK_DIV - 1));

        if (!active_q) begin
            if (go_i) begin
                active_d = 1'b1;
                sclk_d   = 1'b0;
                cmd_d    = tx_i[0];
                tx_d     = tx_i;
                bit_d    = '0;
                div_d    = '0;
            end
        end else if (phase_end) begin
            div_d = '0;
            if (!sclk_q) begin
                sclk_d = 1'b1;
                rx_d   = {data_i, rx_q[7:1]};
            end else if (bit_q == 3'd7) begin
                // done is combinational so the caller leaves SHIFT on the same edge psx_clk stays high
                active_d = 1'b0;
                cmd_d    = 1'b1;
                done_o   = 1'b1;
            end else begin
                sclk_d = 1'b0;
                bit_d  = bit_q + 3'd1;
                cmd_d  = tx_q[1];
                tx_d   = {1'b1, tx_q[7:1]};
            end
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            active_q <= 1'b0;
            sclk_q   <= 1'b1;
            cmd_q    <= 1'b1;
            bit_q    <= '0;
            div_q    <= '0;
            tx_q     <= '1;
            rx_q     <= '0;
        end else begin
            active_q <= active_d;
            sclk_q   <= sclk_d;
            cmd_q    <= cmd_d;
            bit_q    <= bit_d;
            div_q    <= div_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
        end
    end

    always_comb begin
        sclk_o = sclk_q;
        cmd_o  = cmd_q;
        rx_o   = rx_q;
    end

endmodule

// File: rtl/psx_poll_master.sv
// Console-side PSX digital-pad poll master (att/psx_clk/cmd bus, button word out).
// Optional automatic polling is enabled by defining PSX_POLL_AUTO_EN.
module psx_poll_master
    import psx_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned ATT_SETUP   = 8,
    parameter int unsigned ACK_TIMEOUT = 64,
    parameter int unsigned GAP         = 16,
    parameter int unsigned POLL_PERIOD = 4000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        data,
    input  logic        ack,
    output logic        att,
    output logic        psx_clk,
    output logic        cmd,
    output logic [15:0] buttons_n,
    output logic [7:0]  pad_id,
    output logic        valid,
    output logic        error,
    output logic        busy
);

    localparam int unsigned MAX_AG  = (ATT_SETUP > GAP) ? ATT_SETUP : GAP;
    localparam int unsigned CNT_MAX = (ACK_TIMEOUT > MAX_AG) ? ACK_TIMEOUT : MAX_AG;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam logic [2:0]  LAST_BYTE = 3'(PSX_FRAME_BYTES - 1);

    if (CLK_DIV < 4 || POLL_PERIOD < 1) begin : g_bad_params
        $error("psx_poll_master: CLK_DIV must be >= 4 and POLL_PERIOD >= 1");
    end

    psx_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    byte_q, byte_d;
    logic [7:0]    id_q, id_d;
    logic [7:0]    b3_q, b3_d;
    logic          mark_ok_q, mark_ok_d;
    logic [15:0]   buttons_q, buttons_d;
    logic [7:0]    pad_q, pad_d;
    logic          valid_q, valid_d;
    logic          error_q, error_d;
    logic [1:0]    data_sync_q, ack_sync_q;
    logic          data_s, ack_s;
    logic          tick;
    logic          go;
    logic          xfer_done;
    logic [7:0]    xfer_rx;
    logic [7:0]    xfer_tx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_sync_q <= '1;
            ack_sync_q  <= '1;
        end else begin
            data_sync_q <= {data_sync_q[0], data};
            ack_sync_q  <= {ack_sync_q[0], ack};
        end
    end

    always_comb begin
        data_s = data_sync_q[1];
        ack_s  = ack_sync_q[1];
    end

`ifdef PSX_POLL_AUTO_EN
    localparam int unsigned PW = $clog2(POLL_PERIOD + 1);
    logic [PW-1:0] poll_cnt_q, poll_cnt_d;

    always_comb begin
        tick       = (poll_cnt_q == PW'(POLL_PERIOD - 1));
        poll_cnt_d = tick ? '0 : poll_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) poll_cnt_q <= '0;
        else     poll_cnt_q <= poll_cnt_d;
    end
`else
    always_comb tick = 1'b0;
`endif

    always_comb xfer_tx = psx_tx_byte(byte_q);

    psx_byte_xfer #(
        .CLK_DIV(CLK_DIV)
    ) u_xfer (
        .clk_i (clk),
        .rst_i (rst),
        .go_i  (go),
        .tx_i  (xfer_tx),
        .data_i(data_s),
        .sclk_o(psx_clk),
        .cmd_o (cmd),
        .rx_o  (xfer_rx),
        .done_o(xfer_done)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        byte_d    = byte_q;
        id_d      = id_q;
        b3_d      = b3_q;
        mark_ok_d = mark_ok_q;
        buttons_d = buttons_q;
        pad_d     = pad_q;
        valid_d   = 1'b0;
        error_d   = 1'b0;
        go        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start || tick) begin
                    state_d   = ST_SETUP;
                    cnt_d     = '0;
                    byte_d    = '0;
                    mark_ok_d = 1'b0;
                end
            end
            ST_SETUP: begin
                if (cnt_q == CW'(ATT_SETUP - 1)) begin
                    go      = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (xfer_done) begin
                    case (byte_q)
                        3'd1:    id_d = xfer_rx;
                        3'd2:    mark_ok_d = (xfer_rx == PSX_ID_MARK);
                        3'd3:    b3_d = xfer_rx;
                        default: ;
                    endcase
                    cnt_d = '0;
                    if (byte_q == LAST_BYTE) begin
                        state_d = ST_GAP;
                        if (mark_ok_q) begin
                            valid_d   = 1'b1;
                            buttons_d = {xfer_rx, b3_q};
                            pad_d     = id_q;
                        end else begin
                            error_d = 1'b1;
                        end
                    end else begin
                        byte_d  = byte_q + 3'd1;
                        state_d = ST_ACKWAIT;
                    end
                end
            end
            ST_ACKWAIT: begin
                if (!ack_s) begin
                    go      = 1'b1;
                    state_d = ST_SHIFT;
                end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == CW'(GAP - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            byte_q    <= '0;
            id_q      <= '0;
            b3_q      <= '0;
            mark_ok_q <= 1'b0;
            buttons_q <= 16'hFFFF;
            pad_q     <= 8'hFF;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            byte_q    <= byte_d;
            id_q      <= id_d;
            b3_q      <= b3_d;
            mark_ok_q <= mark_ok_d;
            buttons_q <= buttons_d;
            pad_q     <= pad_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
        end
    end

    always_comb begin
        att       = !(state_q inside {ST_SETUP, ST_SHIFT, ST_ACKWAIT});
        busy      = (state_q != ST_IDLE);
        buttons_n = buttons_q;
        pad_id    = pad_q;
        valid     = valid_q;
        error     = error_q;
    end

endmodule

// File: tb/tb_psx_poll_master.sv
// Bench for psx_poll_master: behavioural pad controller plus frame-level reference model.
module tb_psx_poll_master;

    localparam int CLK_DIV     = 4;
    localparam int ATT_SETUP   = 8;
    localparam int ACK_TIMEOUT = 64;
    localparam int GAP         = 16;

    logic        clk = 1'b0;
    logic        rst, start, data, ack;
    logic        att, psx_clk, cmd, valid, error, busy;
    logic [15:0] buttons_n;
    logic [7:0]  pad_id;

    psx_poll_master #(
        .CLK_DIV    (CLK_DIV),
        .ATT_SETUP  (ATT_SETUP),
        .ACK_TIMEOUT(ACK_TIMEOUT),
        .GAP        (GAP),
        .POLL_PERIOD(4000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data     (data),
        .ack      (ack),
        .att      (att),
        .psx_clk  (psx_clk),
        .cmd      (cmd),
        .buttons_n(buttons_n),
        .pad_id   (pad_id),
        .valid    (valid),
        .error    (error),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // controller scenario and observations
    logic [7:0] reply [5];
    int         dly [4];
    int         withhold = -1;
    int         first_fall [5];
    int         last_rise [5];
    logic [7:0] cmd_cap [5];
    int         last_fall = 0;
    int         viol = 0, frames = 0, n_valid = 0, n_error = 0;
    int         bidx = 0, bitn = 0, ack_cnt = 0, ack_hold = 0;
    logic       prev_sclk = 1'b1, prev_cmd = 1'b1, prev_att = 1'b1;

    int          n_checks = 0, n_fail = 0;
    logic [15:0] exp_buttons = 16'hFFFF;
    logic [7:0]  exp_pad = 8'hFF;
    int          exp_nvalid = 0, exp_nerror = 0;

    always @(negedge clk) begin
        if (ack_hold > 0) begin
            ack_hold--;
            if (ack_hold == 0) ack = 1'b1;
        end
        if (ack_cnt > 0) begin
            ack_cnt--;
            if (ack_cnt == 0) begin
                ack      = 1'b0;
                ack_hold = 6;
            end
        end
        if (rst || att) begin
            bidx = 0; bitn = 0; data = 1'b1; ack = 1'b1; ack_cnt = 0; ack_hold = 0;
            if (cmd !== 1'b1 || psx_clk !== 1'b1) viol++;
        end else begin
            if (prev_att) frames++;
            if (prev_sclk && !psx_clk) begin
                if (bitn == 0) first_fall[bidx] = cyc;
                else if (cyc - last_fall != 2 * CLK_DIV) viol++;
                last_fall = cyc;
                data = reply[bidx][bitn];
            end else if (!prev_sclk && psx_clk) begin
                if (cyc - last_fall != CLK_DIV) viol++;
                cmd_cap[bidx][bitn] = cmd;
                if (bitn == 7) begin
                    last_rise[bidx] = cyc;
                    bitn = 0;
                    if (bidx < 4 && bidx != withhold) ack_cnt = dly[bidx];
                    if (bidx < 4) bidx++;
                end else begin
                    bitn++;
                end
            end else if (cmd !== prev_cmd && !(cmd && psx_clk && prev_sclk)) begin
                viol++;
            end
        end
        if (valid) n_valid++;
        if (error) n_error++;
        prev_sclk = psx_clk;
        prev_cmd  = cmd;
        prev_att  = att;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_frame(input bit mid_start);
        logic [7:0] txb [5] = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00};
        int  t0, ev, nb, f0, gap_exp;
        bit  seen, exp_v;
        viol = 0;
        f0   = frames;
        for (int b = 0; b < 5; b++) begin
            first_fall[b] = -1;
            last_rise[b]  = -1;
            cmd_cap[b]    = 8'hEE;
        end
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("att_fall_latency", {31'd0, att}, 0);
        chk("busy_rise_latency", {31'd0, busy}, 1);
        t0   = cyc;
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = (mid_start && i == 150);
            if (valid || error) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        ev    = cyc;
        exp_v = (withhold < 0) && (reply[2] == 8'h5A);
        nb    = (withhold >= 0) ? withhold + 1 : 5;
        chk("frame_end_seen", {31'd0, seen}, 1);
        chk("valid", {31'd0, valid}, {31'd0, exp_v});
        chk("error", {31'd0, error}, {31'd0, !exp_v});
        chk("att_high_at_end", {31'd0, att}, 1);
        if (exp_v) begin
            exp_buttons = {reply[4], reply[3]};
            exp_pad     = reply[1];
            exp_nvalid++;
        end else begin
            exp_nerror++;
        end
        chk("buttons_n", {16'd0, buttons_n}, {16'd0, exp_buttons});
        chk("pad_id", {24'd0, pad_id}, {24'd0, exp_pad});
        chk("end_timing", ev - last_rise[nb-1],
            (withhold >= 0) ? CLK_DIV + ACK_TIMEOUT : CLK_DIV);
        chk("att_setup", first_fall[0] - t0, ATT_SETUP);
        for (int b = 0; b < nb; b++) begin
            chk($sformatf("cmd_byte%0d", b), {24'd0, cmd_cap[b]}, {24'd0, txb[b]});
            chk($sformatf("byte_len%0d", b), last_rise[b] - first_fall[b], 15 * CLK_DIV);
        end
        for (int b = 1; b < nb; b++) begin
            gap_exp = (dly[b-1] + 3 > CLK_DIV + 1) ? dly[b-1] + 3 : CLK_DIV + 1;
            chk($sformatf("ack_gap%0d", b), first_fall[b] - last_rise[b-1], gap_exp);
        end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == 0) chk("pulse_one_cycle", {30'd0, valid, error}, 0);
            if (!busy) break;
        end
        chk("busy_fall", cyc - ev, GAP);
        repeat (20) @(negedge clk);
        chk("frame_count", frames - f0, 1);
        chk("bus_timing_viol", viol, 0);
    endtask

    task automatic set_good(input int d);
        reply[0] = 8'hFF; reply[1] = 8'h41; reply[2] = 8'h5A;
        reply[3] = 8'($urandom); reply[4] = 8'($urandom);
        for (int b = 0; b < 4; b++) dly[b] = d;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst = 1'b1; start = 1'b0; data = 1'b1; ack = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_att", {31'd0, att}, 1);
        chk("rst_psx_clk", {31'd0, psx_clk}, 1);
        chk("rst_cmd", {31'd0, cmd}, 1);
        chk("rst_buttons", {16'd0, buttons_n}, 32'hFFFF);
        chk("rst_pad", {24'd0, pad_id}, 32'hFF);
        chk("rst_pulses_busy", {29'd0, valid, error, busy}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // reference frame: FF/41/5A/FB/7F, ack 10 cycles after each byte
        reply[0] = 8'hFF; reply[1] = 8'h41; reply[2] = 8'h5A; reply[3] = 8'hFB; reply[4] = 8'h7F;
        for (int b = 0; b < 4; b++) dly[b] = 10;
        run_frame(1'b0);
        chk("ref_buttons", {16'd0, buttons_n}, 32'h7FFB);

        // ack withheld after byte 1
        set_good(12);
        withhold = 1;
        run_frame(1'b0);
        withhold = -1;

        // wrong ID mark
        set_good(8);
        reply[2] = 8'h00;
        run_frame(1'b0);

        // ack already low on entry, plus a start pulse mid-frame
        set_good(1);
        run_frame(1'b1);

        // reset in the middle of byte 2
        set_good(10);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!att && bidx == 2 && bitn == 3) begin
                found = 1'b1;
                break;
            end
        end
        chk("reached_byte2", {31'd0, found}, 1);
        rst = 1'b1;
        #1;
        chk("midrst_bus", {29'd0, att, psx_clk, cmd}, 32'h7);
        chk("midrst_buttons", {16'd0, buttons_n}, 32'hFFFF);
        chk("midrst_pad", {24'd0, pad_id}, 32'hFF);
        chk("midrst_pulses_busy", {29'd0, valid, error, busy}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_buttons = 16'hFFFF;
        exp_pad     = 8'hFF;
        repeat (20) @(negedge clk);
        chk("no_partial_pulse", n_valid + n_error, exp_nvalid + exp_nerror);

        // randomized frames
        for (int f = 0; f < 8; f++) begin
            for (int b = 0; b < 5; b++) reply[b] = 8'($urandom);
            if ($urandom_range(0, 3) != 0) reply[2] = 8'h5A;
            for (int b = 0; b < 4; b++) dly[b] = $urandom_range(1, 30);
            withhold = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_frame(1'b0);
        end
        withhold = -1;

        chk("valid_pulse_total", n_valid, exp_nvalid);
        chk("error_pulse_total", n_error, exp_nerror);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
